// File: rtl/fifo_pkg.sv
// Shared sizing and parameter-legality helpers for the FIFO family.
// Pure functions only; evaluated at elaboration time by each FIFO that imports this package.
package fifo_pkg;

   // A depth-1 FIFO still needs a 1-bit pointer so the storage index is never zero-width.
   function automatic int addr_width(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   // Count ranges over 0..depth inclusive, hence depth+1 distinct values.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic bit params_legal(input int data_width, input int depth,
                                       input int af_thresh, input int ae_thresh);
      return (data_width >= 1) && (depth >= 1) &&
             (af_thresh >= 0) && (af_thresh <= depth) &&
             (ae_thresh >= 0) && (ae_thresh <= depth);
   endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Circular pointer register that wraps at DEPTH-1 to 0, so any depth works.
// Latency: updates on the clock edge after inc/clr; clr has priority over inc; no backpressure.
module fifo_ptr_wrap #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  inc,
   output logic [ADDR_WIDTH-1:0] ptr
);

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == LAST) ? '0 : ptr + ADDR_WIDTH'(1);
      end
   end

endmodule

// File: rtl/fifo_stream_flush.sv
// Flushable valid/ready FIFO of any depth with occupancy count, almost flags and high-water mark.
// Latency: a pushed word reaches out_valid/out_data one cycle after the push edge (no empty bypass).
// Backpressure: in_ready = not full, independent of out_ready (no full bypass); out_valid = not empty.
module fifo_stream_flush
   import fifo_pkg::*;
#(
   parameter int  DATA_WIDTH = 32,
   parameter int  FIFO_DEPTH = 4,
   parameter int  AF_THRESH  = FIFO_DEPTH - 1,
   parameter int  AE_THRESH  = 1,
   localparam int ADDR_WIDTH = addr_width(FIFO_DEPTH),
   localparam int CNT_WIDTH  = cnt_width(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CNT_WIDTH-1:0]  hwm,
   input  logic                  hwm_clr
);

   if (!params_legal(DATA_WIDTH, FIFO_DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
      $fatal(1, "fifo_stream_flush: illegal DATA_WIDTH/FIFO_DEPTH/threshold parameters");
   end

   localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AF_THRESH);
   localparam logic [CNT_WIDTH-1:0] AE_C    = CNT_WIDTH'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] w_ptr;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic                  push;
   logic                  pop;
   logic [CNT_WIDTH-1:0]  count_next;
   logic [CNT_WIDTH-1:0]  hwm_next;

   // Full/empty come from the count register only, never from pointer comparison.
   assign in_ready     = (count != DEPTH_C);
   assign out_valid    = (count != '0);
   assign push         = in_valid & in_ready;
   assign pop          = out_valid & out_ready;
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);
   assign out_data     = mem[r_ptr];

   fifo_ptr_wrap #(
      .DEPTH      (FIFO_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_w_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .inc   (push),
      .ptr   (w_ptr)
   );

   fifo_ptr_wrap #(
      .DEPTH      (FIFO_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_r_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (flush),
      .inc   (pop),
      .ptr   (r_ptr)
   );

   always_comb begin
      count_next = count;
      hwm_next   = hwm;
      if (flush) begin
         count_next = '0;
      end else begin
         count_next = count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
      end
      // Flush forces count_next to 0, so flush+hwm_clr clears and flush alone leaves hwm alone.
      if (hwm_clr) begin
         hwm_next = count_next;
      end else if (count_next > hwm) begin
         hwm_next = count_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         hwm   <= '0;
      end else begin
         count <= count_next;
         hwm   <= hwm_next;
      end
   end

   // Storage survives flush; out_data is only meaningful while out_valid is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push && !flush) begin
         mem[w_ptr] <= in_data;
      end
   end

   a_count_range : assert property (@(posedge clk) disable iff (!rst_n) count <= DEPTH_C);
   a_wptr_range  : assert property (@(posedge clk) disable iff (!rst_n) w_ptr <= ADDR_WIDTH'(FIFO_DEPTH - 1));
   a_rptr_range  : assert property (@(posedge clk) disable iff (!rst_n) r_ptr <= ADDR_WIDTH'(FIFO_DEPTH - 1));

endmodule

// File: doc/fifo_stream_flush.md
Name: fifo_stream_flush

Overview:
Parametrised synchronous FIFO with flush, the next generation of the team's flushable FIFO. Adds a valid/ready stream handshake on both sides, support for any depth (not only powers of two), and an occupancy count. Also adds programmable almost-full/almost-empty flags and a clearable high-water mark. Used between pipeline stages in the SM front end and memory paths, where back-pressure, early throttling and occupancy profiling are needed.

Parameters:
DATA_WIDTH, 32, payload width in bits (>=1)
FIFO_DEPTH, 4, number of entries, any integer >=1, non-power-of-two legal
AF_THRESH, FIFO_DEPTH-1, almost_full asserts when count >= AF_THRESH (0..FIFO_DEPTH)
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..FIFO_DEPTH)
Localparams: ADDR_WIDTH = (FIFO_DEPTH==1) ? 1 : $clog2(FIFO_DEPTH); CNT_WIDTH = $clog2(FIFO_DEPTH+1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush, highest priority
in_valid  in  1  producer has data
in_ready  out  1  FIFO can accept data
in_data  in  DATA_WIDTH  write payload
out_valid  out  1  head entry valid
out_ready  in  1  consumer takes head entry
out_data  out  DATA_WIDTH  head entry payload (first-word-fall-through)
count  out  CNT_WIDTH  current occupancy, 0..FIFO_DEPTH
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
hwm  out  CNT_WIDTH  maximum occupancy since reset or last hwm_clr
hwm_clr  in  1  clears the high-water mark

Behaviour:
- Reset: clk is the clock; rst_n is asynchronous, active-low. On reset: w_ptr=r_ptr=0, count=0, hwm=0, storage=0.
- Output values at reset: in_ready=1, out_valid=0, out_data=0, almost_empty=1, almost_full=(AF_THRESH==0).
- Handshake: push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != FIFO_DEPTH). out_valid = (count != 0).
- Producer holds in_valid/in_data until accepted. in_valid with in_ready low is legal back-pressure, not an error.
- Latency: a pushed word is visible on out_data/out_valid the cycle after the push edge. There is no same-cycle empty bypass.
- Full: in_ready=0 even if out_ready=1 in the same cycle (no full bypass). This keeps in_ready independent of out_ready, with no comb path between them.
- Simultaneous push and pop when 0<count<DEPTH: both execute and count is unchanged.
- Simultaneous push and pop when empty: only the push occurs, because out_valid=0.
- Pointers: range 0..FIFO_DEPTH-1. Increment wraps from FIFO_DEPTH-1 to 0 (explicit compare, not a power-of-two rollover).
- Full/empty are derived from count, not from pointer MSBs.
- count_next = count + push - pop. It never leaves 0..FIFO_DEPTH.
- Storage write: on push, entry[w_ptr] <= in_data. out_data = entry[r_ptr] (combinational mux).
- Flush (synchronous):
  - w_ptr, r_ptr and count go to 0; any push or pop in the same cycle is discarded.
  - Storage is not cleared, so out_data is meaningful only while out_valid=1.
  - hwm is unaffected by flush.
- Flags are combinational from the count register. Both may be asserted together when the thresholds overlap.
- High-water mark:
  - hwm <= max(hwm, count_next) every cycle.
  - If hwm_clr=1: hwm <= count_next (clear wins, then tracks the current level).
  - When flush and hwm_clr are both high: hwm <= 0.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). In-flight data is lost.
- Illegal parameters (FIFO_DEPTH<1, thresholds >FIFO_DEPTH) are rejected by an elaboration-time check.

Decomposition:
- Shared header/package fifo_pkg: CNT_WIDTH/ADDR_WIDTH calculation functions (clog2 with DEPTH==1 guard) and the parameter-legality check, reusable by other FIFOs.
- One sub-module, fifo_ptr_wrap (params DEPTH, ADDR_WIDTH; inputs clk, rst_n, clr, inc; output ptr): a wrap-at-DEPTH pointer register. It is instantiated twice, once for the write pointer and once for the read pointer.
- Count, flags, hwm and storage stay in the top module.

Test Plan:
- DEPTH=4: push 0xA1..0xA4 with out_ready=0 -> in_ready falls after the 4th push, count=4, almost_full=1, hwm=4. Then out_ready=1 -> out_data A1,A2,A3,A4 on successive cycles, count goes 3,2,1,0, out_valid drops.
- DEPTH=3 (non-power-of-two): 10 continuous push/pop cycles with data 0..9 -> pointers wrap 2->0, output order 0..9, count never exceeds 1.
- Full with in_valid=1 and out_ready=1 -> one pop and no push that cycle, count 4->3. The next cycle the push is accepted, count=4.
- Fill to 3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1, almost_empty=1, hwm stays 3. A subsequent push of 0x55 appears on out_data one cycle later.
- hwm_clr at count=2 with a simultaneous push -> hwm=3. Same cycle as flush -> hwm=0.
- Assert rst_n=0 asynchronously mid-stream at count=2 -> count, hwm, out_valid and out_data go to 0 before the next clock edge, and in_ready=1.
